// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a 2-entry FIFO between fetch and decode.
// The head entry is decoded combinationally into the instruction fields.
module if_id_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [5:0]  out_funct,
  output logic [15:0] out_imm16,
  output logic [31:0] out_pc_plus4,
  output logic        out_is_nop
);

  logic [1:0]  count_r;
  logic [31:0] head_instr_r;
  logic [31:0] head_pc_r;
  logic [31:0] tail_instr_r;
  logic [31:0] tail_pc_r;
  logic        push_s;
  logic        pop_s;

  // Handshake: in_ready is held low during reset and never looks at out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end else begin
      in_ready  = (count_r != 2'd2) && !flush;
      out_valid = (count_r != 2'd0);
    end
    push_s = in_valid && in_ready;
    pop_s  = out_valid && out_ready;
  end

  // FIFO state: flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r      <= 2'd0;
      head_instr_r <= 32'h0000_0000;
      head_pc_r    <= 32'h0000_0000;
      tail_instr_r <= 32'h0000_0000;
      tail_pc_r    <= 32'h0000_0000;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            head_instr_r <= in_instr;
            head_pc_r    <= in_pc;
            count_r      <= 2'd1;
          end
        end
        2'd1: begin
          // Simultaneous push and pop replaces the head directly.
          if (push_s && pop_s) begin
            head_instr_r <= in_instr;
            head_pc_r    <= in_pc;
          end else if (push_s) begin
            tail_instr_r <= in_instr;
            tail_pc_r    <= in_pc;
            count_r      <= 2'd2;
          end else if (pop_s) begin
            count_r <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_instr_r <= tail_instr_r;
            head_pc_r    <= tail_pc_r;
            count_r      <= 2'd1;
          end
        end
        default: begin
          count_r <= 2'd0;
        end
      endcase
    end
  end

  // Field decode of the head entry.
  always_comb begin
    out_opcode   = head_instr_r[31:26];
    out_rs       = head_instr_r[25:21];
    out_rt       = head_instr_r[20:16];
    out_rd       = head_instr_r[15:11];
    out_shamt    = head_instr_r[10:6];
    out_funct    = head_instr_r[5:0];
    out_imm16    = head_instr_r[15:0];
    out_pc_plus4 = head_pc_r + 32'd4;
    out_is_nop   = (head_instr_r == 32'h0000_0000);
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic [31:0] out_pc_plus4;
  logic        out_is_nop;

  int errors = 0;
  int checks = 0;

  // Reference model: each element is {instr, pc}, front is the head.
  logic [63:0] model_q[$];

  if_id_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .out_pc_plus4(out_pc_plus4), .out_is_nop(out_is_nop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all visible outputs against the model; fields only when valid.
  task automatic check_model(input string tag);
    logic [31:0] hi;
    logic [31:0] hp;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, model_q.size() != 0});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (model_q.size() < 2) && !flush});
    if (model_q.size() != 0) begin
      hi = model_q[0][63:32];
      hp = model_q[0][31:0];
      chk({tag, ".opcode"}, {26'd0, out_opcode}, {26'd0, hi[31:26]});
      chk({tag, ".rs"}, {27'd0, out_rs}, {27'd0, hi[25:21]});
      chk({tag, ".rt"}, {27'd0, out_rt}, {27'd0, hi[20:16]});
      chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, hi[15:11]});
      chk({tag, ".shamt"}, {27'd0, out_shamt}, {27'd0, hi[10:6]});
      chk({tag, ".funct"}, {26'd0, out_funct}, {26'd0, hi[5:0]});
      chk({tag, ".imm16"}, {16'd0, out_imm16}, {16'd0, hi[15:0]});
      chk({tag, ".pc_plus4"}, out_pc_plus4, hp + 32'd4);
      chk({tag, ".is_nop"}, {31'd0, out_is_nop}, {31'd0, hi == 32'd0});
    end
  endtask

  // One clock cycle: drive, check before the edge, update model at the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ord, input logic fl, input string tag);
    logic rdy;
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ord;
    flush     = fl;
    #3;
    check_model(tag);
    rdy     = (model_q.size() < 2) && !fl;
    do_push = v && rdy;
    do_pop  = (model_q.size() != 0) && ord;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({ins, pc});
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    logic [31:0] ri;
    logic [31:0] rp;
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.is_nop", {31'd0, out_is_nop}, 32'd1);
    chk("rst.pc_plus4", out_pc_plus4, 32'h0000_0004);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single push, decoded fields visible the next cycle.
    step(1'b1, 32'h2008FFFF, 32'h00400000, 1'b0, 1'b0, "push1");
    chk("d35.out_valid", {31'd0, out_valid}, 32'd1);
    chk("d35.opcode", {26'd0, out_opcode}, 32'h08);
    chk("d35.rs", {27'd0, out_rs}, 32'd0);
    chk("d35.rt", {27'd0, out_rt}, 32'd8);
    chk("d35.imm16", {16'd0, out_imm16}, 32'h0000FFFF);
    chk("d35.pc_plus4", out_pc_plus4, 32'h00400004);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "drain1");

    // Fill to two, then pop once.
    step(1'b1, 32'h8C410004, 32'h00001000, 1'b0, 1'b0, "pushA");
    step(1'b1, 32'hAC620008, 32'h00001004, 1'b0, 1'b0, "pushB");
    chk("d36.in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("d36.headA", {16'd0, out_imm16}, 32'h00000004);
    step(1'b1, 32'h11111111, 32'h00002000, 1'b0, 1'b0, "push_full_dropped");
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "popA");
    chk("d36.headB", {16'd0, out_imm16}, 32'h00000008);
    chk("d36.in_ready", {31'd0, in_ready}, 32'd1);

    // Push and pop together at count 1.
    step(1'b1, 32'h00A41020, 32'h00003000, 1'b1, 1'b0, "pushpopC");
    chk("d37.out_valid", {31'd0, out_valid}, 32'd1);
    chk("d37.headC_pc", out_pc_plus4, 32'h00003004);
    chk("d37.headC_funct", {26'd0, out_funct}, 32'h20);

    // Flush with everything asserted at count 2.
    step(1'b1, 32'h22222222, 32'h00004000, 1'b0, 1'b0, "pushD");
    step(1'b1, 32'h33333333, 32'h00005000, 1'b1, 1'b1, "flush");
    chk("d38.out_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "after_flush");

    // NOP at the top of the address space wraps pc+4.
    step(1'b1, 32'h00000000, 32'hFFFFFFFC, 1'b0, 1'b0, "push_nop");
    chk("d39.is_nop", {31'd0, out_is_nop}, 32'd1);
    chk("d39.pc_wrap", out_pc_plus4, 32'h00000000);

    // Asynchronous reset mid-cycle with count 2.
    step(1'b1, 32'h44444444, 32'h00006000, 1'b0, 1'b0, "push_fill");
    #2;
    rst = 1'b1;
    #1;
    chk("d40.out_valid_async", {31'd0, out_valid}, 32'd0);
    chk("d40.in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    model_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("d40.in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("d40.is_nop_after", {31'd0, out_is_nop}, 32'd1);
    chk("d40.pc_plus4_after", out_pc_plus4, 32'h00000004);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      rp = $urandom;
      if ($urandom_range(0, 7) == 0) rp = 32'hFFFFFFFC;
      step(($urandom_range(0, 3) != 0), ri, {rp[31:2], 2'b00},
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0t expected <100000", $time);
    $fatal(1, "timeout");
  end

endmodule
